// File: rtl/atm_controller_param_pkg.sv
// Shared types for the parametrised ATM session controller.
// Session states and the bundle of one-cycle event pulses.
package atm_controller_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIN,
    ST_TRANS,
    ST_LOCK
  } atm_state_e;

  typedef struct packed {
    logic upd;
    logic dispense;
    logic pin_bad;
    logic tmo;
    logic no_funds;
    logic over_limit;
  } atm_pulse_t;

endpackage

// File: rtl/atm_controller_param_pin_entry.sv
// PIN entry: keypad strobe edge detect, MS-first digit shift register,
// digit counter and compare against the stored PIN.
module atm_controller_param_pin_entry #(
  parameter int unsigned PIN_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter logic [PIN_DIGITS*DIGIT_W-1:0] PIN = 16'h4756
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               digito_stb_i,
  input  logic [DIGIT_W-1:0] digito_i,
  output logic               edge_o,
  output logic               pin_ok_o,
  output logic               pin_bad_o
);

  localparam int unsigned PW = PIN_DIGITS * DIGIT_W;
  localparam int unsigned CW = $clog2(PIN_DIGITS + 1);

  logic          stb_q;
  logic [PW-1:0] sr_q;
  logic [PW-1:0] full;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          take;
  logic          last;

  assign edge_o    = digito_stb_i & ~stb_q;
  assign take      = en_i & edge_o;
  assign full      = (sr_q << DIGIT_W) | PW'(digito_i);
  assign last      = (cnt_q == CW'(PIN_DIGITS - 1));
  assign pin_ok_o  = take & last & (full == PIN);
  assign pin_bad_o = take & last & (full != PIN);

  // Partial entries are dropped as soon as the session leaves PIN entry
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (take) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= 1'b0;
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      stb_q <= digito_stb_i;
      cnt_q <= cnt_d;
      if (take) begin
        sr_q <= full;
      end
    end
  end

endmodule

// File: rtl/atm_controller_param.sv
// Parametrised ATM session controller: card, PIN with lockout,
// deposit/withdrawal with daily limit, inactivity timeout.
module atm_controller_param
  import atm_controller_param_pkg::*;
#(
  parameter int unsigned PIN_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter logic [PIN_DIGITS*DIGIT_W-1:0] PIN = 16'h4756,
  parameter int unsigned MONTO_W    = 32,
  parameter int unsigned BAL_W      = 64,
  parameter longint unsigned INIT_BALANCE = 5000,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter longint unsigned DAILY_LIMIT = 20000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tarjeta_recibida,
  input  logic               digito_stb,
  input  logic [DIGIT_W-1:0] digito,
  input  logic               tipo_trans,
  input  logic               monto_stb,
  input  logic [MONTO_W-1:0] monto,
  input  logic               dia_nuevo,
  output logic               balance_actualizado,
  output logic               entregar_dinero,
  output logic               pin_incorrecto,
  output logic               advertencia,
  output logic               bloqueo,
  output logic               fondos_insuficientes,
  output logic               limite_excedido,
  output logic               timeout,
  output logic [BAL_W-1:0]   balance
);

  localparam int unsigned BW1 = BAL_W + 1;
  localparam int unsigned AW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TW  =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [BAL_W-1:0] INIT_B = BAL_W'(INIT_BALANCE);
  localparam logic [BAL_W:0]   LIMIT  = BW1'(DAILY_LIMIT);
  localparam logic [AW-1:0]    ATT_LAST = AW'(MAX_ATTEMPTS - 1);
  localparam logic [AW-1:0]    ATT_WARN = AW'(MAX_ATTEMPTS - 2);

  atm_state_e       st_q;
  atm_pulse_t       pul_q;
  logic [AW-1:0]    att_q;
  logic [BAL_W-1:0] bal_q;
  logic [BAL_W-1:0] daily_q;
  logic [TW-1:0]    tmr_q;
  logic             mstb_q;
  logic             adv_q;
  logic             lock_q;

  logic             d_edge;
  logic             m_edge;
  logic             pin_ok;
  logic             pin_bad;
  logic             tmr_hit;
  logic [BAL_W-1:0] monto_x;
  logic [BAL_W-1:0] daily_eff;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W:0]   wd_sum;
  logic             no_funds;
  logic             over;

  atm_controller_param_pin_entry #(
    .PIN_DIGITS(PIN_DIGITS),
    .DIGIT_W   (DIGIT_W),
    .PIN       (PIN)
  ) u_pin (
    .clk         (clk),
    .rst_n       (rst),
    .en_i        (st_q == ST_PIN),
    .digito_stb_i(digito_stb),
    .digito_i    (digito),
    .edge_o      (d_edge),
    .pin_ok_o    (pin_ok),
    .pin_bad_o   (pin_bad)
  );

  assign m_edge    = monto_stb & ~mstb_q;
  assign tmr_hit   = TO_EN && (tmr_q == TO_LAST);
  assign monto_x   = BAL_W'(monto);
  assign daily_eff = dia_nuevo ? '0 : daily_q;
  assign dep_sum   = {1'b0, bal_q} + {1'b0, monto_x};
  // One extra bit so daily + monto can never wrap past the limit
  assign wd_sum    = {1'b0, daily_eff} + {1'b0, monto_x};
  assign no_funds  = monto_x > bal_q;
  assign over      = wd_sum > LIMIT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= ST_IDLE;
      pul_q   <= '0;
      att_q   <= '0;
      bal_q   <= INIT_B;
      daily_q <= '0;
      tmr_q   <= '0;
      mstb_q  <= 1'b0;
      adv_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      mstb_q  <= monto_stb;
      pul_q   <= '0;
      daily_q <= daily_eff;
      unique case (st_q)
        ST_IDLE: begin
          tmr_q <= '0;
          if (tarjeta_recibida) begin
            st_q <= ST_PIN;
          end
        end
        ST_PIN: begin
          if (pin_ok) begin
            att_q <= '0;
            adv_q <= 1'b0;
            tmr_q <= '0;
            st_q  <= ST_TRANS;
          end else if (pin_bad) begin
            pul_q.pin_bad <= 1'b1;
            tmr_q <= '0;
            att_q <= att_q + 1'b1;
            if (att_q == ATT_LAST) begin
              lock_q <= 1'b1;
              adv_q  <= 1'b0;
              st_q   <= ST_LOCK;
            end else if (att_q == ATT_WARN) begin
              adv_q <= 1'b1;
            end
          end else if (d_edge || m_edge) begin
            tmr_q <= '0;
          end else if (tmr_hit) begin
            pul_q.tmo <= 1'b1;
            tmr_q <= '0;
            st_q  <= ST_IDLE;
          end else if (TO_EN) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_TRANS: begin
          if (m_edge) begin
            tmr_q <= '0;
            st_q  <= ST_IDLE;
            if (!tipo_trans) begin
              bal_q <= dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
              pul_q.upd <= 1'b1;
            end else if (no_funds) begin
              pul_q.no_funds <= 1'b1;
            end else if (over) begin
              pul_q.over_limit <= 1'b1;
            end else begin
              bal_q   <= bal_q - monto_x;
              daily_q <= wd_sum[BAL_W-1:0];
              pul_q.dispense <= 1'b1;
              pul_q.upd      <= 1'b1;
            end
          end else if (d_edge) begin
            tmr_q <= '0;
          end else if (tmr_hit) begin
            pul_q.tmo <= 1'b1;
            tmr_q <= '0;
            st_q  <= ST_IDLE;
          end else if (TO_EN) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_LOCK: begin
          tmr_q <= '0;
        end
      endcase
    end
  end

  assign balance_actualizado  = pul_q.upd;
  assign entregar_dinero      = pul_q.dispense;
  assign pin_incorrecto       = pul_q.pin_bad;
  assign fondos_insuficientes = pul_q.no_funds;
  assign limite_excedido      = pul_q.over_limit;
  assign timeout              = pul_q.tmo;
  assign advertencia          = adv_q;
  assign bloqueo              = lock_q;
  assign balance              = bal_q;

endmodule

// File: tb/tb_atm_controller_param.sv
// Self-checking bench for atm_controller_param: directed scenarios
// plus a randomized run against a session-level reference model.
module tb_atm_controller_param;

  localparam int T      = 20;
  localparam int LIMIT  = 2000;
  localparam int MAXATT = 3;

  typedef struct packed {
    logic upd;
    logic ent;
    logic pinc;
    logic adv;
    logic bloq;
    logic fond;
    logic lim;
    logic tmo;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tarjeta_recibida;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        tipo_trans;
  logic        monto_stb;
  logic [31:0] monto;
  logic        dia_nuevo;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;
  logic        limite_excedido;
  logic        timeout;
  logic [31:0] balance;

  int n_chk  = 0;
  int n_fail = 0;

  atm_controller_param #(
    .PIN_DIGITS    (4),
    .DIGIT_W       (4),
    .PIN           (16'h4756),
    .MONTO_W       (32),
    .BAL_W         (32),
    .INIT_BALANCE  (5000),
    .MAX_ATTEMPTS  (MAXATT),
    .DAILY_LIMIT   (LIMIT),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tarjeta_recibida    (tarjeta_recibida),
    .digito_stb          (digito_stb),
    .digito              (digito),
    .tipo_trans          (tipo_trans),
    .monto_stb           (monto_stb),
    .monto               (monto),
    .dia_nuevo           (dia_nuevo),
    .balance_actualizado (balance_actualizado),
    .entregar_dinero     (entregar_dinero),
    .pin_incorrecto      (pin_incorrecto),
    .advertencia         (advertencia),
    .bloqueo             (bloqueo),
    .fondos_insuficientes(fondos_insuficientes),
    .limite_excedido     (limite_excedido),
    .timeout             (timeout),
    .balance             (balance)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic obs_t snap();
    return {balance_actualizado, entregar_dinero, pin_incorrecto,
            advertencia, bloqueo, fondos_insuficientes,
            limite_excedido, timeout};
  endfunction

  function automatic obs_t mk(input logic a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tarjeta_recibida = 0; digito_stb = 0; digito = 0;
    tipo_trans = 0; monto_stb = 0; monto = 0; dia_nuevo = 0;
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic card();
    tarjeta_recibida = 1;
    tick();
    tarjeta_recibida = 0;
    tick();
  endtask

  task automatic key(input logic [3:0] d, output obs_t o);
    digito = d;
    digito_stb = 1;
    tick();
    o = snap();
    digito_stb = 0;
    tick();
  endtask

  task automatic enter_pin(input logic [15:0] p, output obs_t o);
    for (int i = 0; i < 4; i++) key(p[15-4*i -: 4], o);
  endtask

  task automatic txn(input logic t, input logic [31:0] a, output obs_t o);
    tipo_trans = t;
    monto = a;
    monto_stb = 1;
    tick();
    o = snap();
    monto_stb = 0;
    tick();
  endtask

  task automatic new_day();
    dia_nuevo = 1;
    tick();
    dia_nuevo = 0;
  endtask

  task automatic test_reset();
    obs_t o;
    tarjeta_recibida = 0; digito_stb = 0; digito = 0;
    tipo_trans = 0; monto_stb = 0; monto = 0; dia_nuevo = 0;
    rst = 0;
    tick();
    o = snap();
    n_chk++;
    if (o !== '0 || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL reset_state: got %b bal %0d want 0 bal 5000", o, balance);
    end
    rst = 1;
    tick();
    o = snap();
    n_chk++;
    if (o !== '0 || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL reset_release: got %b bal %0d want 0 bal 5000", o, balance);
    end
  endtask

  task automatic test_deposit();
    obs_t o;
    do_reset();
    card();
    enter_pin(16'h4756, o);
    n_chk++;
    if (o !== '0) begin
      n_fail++; $display("FAIL dep_pin: got %b want 0", o);
    end
    txn(1'b0, 32'd10000, o);
    n_chk++;
    if (o !== mk(1,0,0,0,0,0,0,0) || balance !== 32'd15000) begin
      n_fail++;
      $display("FAIL dep_pulse: got %b bal %0d want 10000000 bal 15000", o, balance);
    end
    n_chk++;
    if (snap() !== '0) begin
      n_fail++; $display("FAIL dep_one_cycle: got %b want 0", snap());
    end
    txn(1'b0, 32'd5, o);
    n_chk++;
    if (o !== '0 || balance !== 32'd15000) begin
      n_fail++;
      $display("FAIL dep_idle_ignored: got %b bal %0d want 0 bal 15000", o, balance);
    end
  endtask

  task automatic test_warning();
    obs_t o;
    do_reset();
    card();
    enter_pin(16'h4757, o);
    n_chk++;
    if (o !== mk(0,0,1,0,0,0,0,0)) begin
      n_fail++; $display("FAIL warn_first: got %b want 00100000", o);
    end
    enter_pin(16'h4757, o);
    n_chk++;
    if (o !== mk(0,0,1,1,0,0,0,0)) begin
      n_fail++; $display("FAIL warn_second: got %b want 00110000", o);
    end
    enter_pin(16'h4756, o);
    n_chk++;
    if (o !== '0) begin
      n_fail++; $display("FAIL warn_clear: got %b want 0", o);
    end
    txn(1'b1, 32'd1000, o);
    n_chk++;
    if (o !== mk(1,1,0,0,0,0,0,0) || balance !== 32'd4000) begin
      n_fail++;
      $display("FAIL warn_withdraw: got %b bal %0d want 11000000 bal 4000", o, balance);
    end
  endtask

  task automatic test_lock();
    obs_t o;
    do_reset();
    card();
    for (int i = 0; i < MAXATT; i++) enter_pin(16'h4757, o);
    n_chk++;
    if (o.bloq !== 1'b1 || o.pinc !== 1'b1) begin
      n_fail++; $display("FAIL lock_enter: got %b want bloq=1 pinc=1", o);
    end
    card();
    enter_pin(16'h4756, o);
    txn(1'b0, 32'd100, o);
    n_chk++;
    if (o.bloq !== 1'b1 || o.upd !== 1'b0 || o.pinc !== 1'b0 || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL lock_absorb: got %b bal %0d want bloq only bal 5000", o, balance);
    end
    rst = 0;
    tick();
    rst = 1;
    o = snap();
    n_chk++;
    if (o !== '0 || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL lock_reset: got %b bal %0d want 0 bal 5000", o, balance);
    end
    tick();
    card();
    enter_pin(16'h4756, o);
    txn(1'b0, 32'd0, o);
    n_chk++;
    if (o !== mk(1,0,0,0,0,0,0,0) || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL lock_after_reset: got %b bal %0d want 10000000 bal 5000", o, balance);
    end
  endtask

  task automatic test_funds();
    obs_t o;
    do_reset();
    card();
    enter_pin(16'h4756, o);
    txn(1'b1, 32'd6000, o);
    n_chk++;
    if (o !== mk(0,0,0,0,0,1,0,0) || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL funds: got %b bal %0d want 00000100 bal 5000", o, balance);
    end
  endtask

  task automatic test_limit();
    obs_t o;
    do_reset();
    card();
    enter_pin(16'h4756, o);
    txn(1'b1, 32'd1500, o);
    n_chk++;
    if (o !== mk(1,1,0,0,0,0,0,0) || balance !== 32'd3500) begin
      n_fail++;
      $display("FAIL limit_first: got %b bal %0d want 11000000 bal 3500", o, balance);
    end
    card();
    enter_pin(16'h4756, o);
    txn(1'b1, 32'd1000, o);
    n_chk++;
    if (o !== mk(0,0,0,0,0,0,1,0) || balance !== 32'd3500) begin
      n_fail++;
      $display("FAIL limit_exceed: got %b bal %0d want 00000010 bal 3500", o, balance);
    end
    new_day();
    card();
    enter_pin(16'h4756, o);
    txn(1'b1, 32'd1000, o);
    n_chk++;
    if (o !== mk(1,1,0,0,0,0,0,0) || balance !== 32'd2500) begin
      n_fail++;
      $display("FAIL limit_new_day: got %b bal %0d want 11000000 bal 2500", o, balance);
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    do_reset();
    card();
    enter_pin(16'h4756, o);
    txn(1'b0, 32'hFFFF_FFFF, o);
    n_chk++;
    if (o !== mk(1,0,0,0,0,0,0,0) || balance !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL saturate: got %b bal %h want 10000000 bal ffffffff", o, balance);
    end
  endtask

  task automatic test_hold();
    obs_t o;
    do_reset();
    card();
    digito = 4'd4;
    digito_stb = 1;
    tick(); tick(); tick();
    digito_stb = 0;
    tick();
    key(4'd7, o);
    key(4'd5, o);
    key(4'd6, o);
    txn(1'b1, 32'd100, o);
    n_chk++;
    if (o !== mk(1,1,0,0,0,0,0,0) || balance !== 32'd4900) begin
      n_fail++;
      $display("FAIL hold_once: got %b bal %0d want 11000000 bal 4900", o, balance);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    int got;
    do_reset();
    card();
    enter_pin(16'h4757, o);
    key(4'd4, o);
    key(4'd7, o);
    got = -1;
    for (int c = 1; c <= 3 * T; c++) begin
      tick();
      if (timeout === 1'b1) begin
        got = c;
        break;
      end
    end
    n_chk++;
    if (got != T - 1) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d want %0d", got, T - 1);
    end
    tick();
    n_chk++;
    if (snap() !== '0) begin
      n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", snap());
    end
    card();
    enter_pin(16'h4757, o);
    n_chk++;
    if (o !== mk(0,0,1,1,0,0,0,0)) begin
      n_fail++; $display("FAIL timeout_attempts: got %b want 00110000", o);
    end
    enter_pin(16'h4756, o);
    txn(1'b0, 32'd0, o);
    n_chk++;
    if (o !== mk(1,0,0,0,0,0,0,0) || balance !== 32'd5000) begin
      n_fail++;
      $display("FAIL timeout_resume: got %b bal %0d want 10000000 bal 5000", o, balance);
    end
  endtask

  int              pin_dig[4] = '{4, 7, 5, 6};
  longint unsigned m_bal;
  longint unsigned m_daily;
  int              m_att;
  int              m_idle;
  int              m_q[$];
  bit              m_lock, m_pin, m_trans, m_pd, m_pm, m_adv, m_bloq;
  obs_t            m_exp;

  task automatic model_step();
    bit de;
    bit me;
    bit ok;
    longint unsigned s;
    de = digito_stb && !m_pd;
    me = monto_stb && !m_pm;
    m_pd = digito_stb;
    m_pm = monto_stb;
    m_exp = '0;
    if (dia_nuevo) m_daily = 0;
    if (m_lock) begin
    end else if (!m_pin && !m_trans) begin
      if (tarjeta_recibida) begin
        m_pin = 1;
        m_idle = 0;
      end
    end else if (m_pin && de) begin
      m_idle = 0;
      m_q.push_back(int'(digito));
      if (m_q.size() == 4) begin
        ok = 1;
        for (int i = 0; i < 4; i++) if (m_q[i] != pin_dig[i]) ok = 0;
        m_q.delete();
        if (ok) begin
          m_att = 0; m_adv = 0; m_pin = 0; m_trans = 1;
        end else begin
          m_att++;
          m_exp.pinc = 1;
          if (m_att == MAXATT) begin
            m_lock = 1; m_bloq = 1; m_adv = 0; m_pin = 0;
          end else if (m_att == MAXATT - 1) begin
            m_adv = 1;
          end
        end
      end
    end else if (m_trans && me) begin
      m_idle = 0;
      m_trans = 0;
      if (!tipo_trans) begin
        s = m_bal + monto;
        m_bal = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
        m_exp.upd = 1;
      end else if (monto > m_bal) begin
        m_exp.fond = 1;
      end else if (m_daily + monto > LIMIT) begin
        m_exp.lim = 1;
      end else begin
        m_bal = m_bal - monto;
        m_daily = m_daily + monto;
        m_exp.ent = 1;
        m_exp.upd = 1;
      end
    end else if (de || me) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == T) begin
        m_exp.tmo = 1;
        m_pin = 0; m_trans = 0; m_idle = 0;
        m_q.delete();
      end
    end
    m_exp.adv = m_adv;
    m_exp.bloq = m_bloq;
  endtask

  task automatic test_random();
    obs_t o;
    do_reset();
    m_bal = 5000; m_daily = 0; m_att = 0; m_idle = 0; m_q.delete();
    m_lock = 0; m_pin = 0; m_trans = 0; m_pd = 0; m_pm = 0;
    m_adv = 0; m_bloq = 0;
    for (int c = 0; c < 2400; c++) begin
      if ((c % 300) >= 270) begin
        tarjeta_recibida = 0; digito_stb = 0; monto_stb = 0; dia_nuevo = 0;
      end else begin
        tarjeta_recibida = ($urandom_range(0, 9) == 0);
        digito_stb = $urandom_range(0, 1);
        if (m_att == MAXATT - 1 || $urandom_range(0, 3) != 0)
          digito = 4'(pin_dig[m_q.size()]);
        else
          digito = 4'($urandom_range(0, 15));
        monto_stb = ($urandom_range(0, 2) == 0);
        tipo_trans = $urandom_range(0, 1);
        case ($urandom_range(0, 9))
          0: monto = 32'd0;
          1: monto = 32'($urandom_range(5000, 20000));
          default: monto = 32'($urandom_range(1, 1800));
        endcase
        dia_nuevo = ($urandom_range(0, 29) == 0);
      end
      model_step();
      tick();
      o = snap();
      n_chk++;
      if (o !== m_exp || balance !== 32'(m_bal)) begin
        n_fail++;
        $display("FAIL random_c%0d: got %b bal %0d want %b bal %0d",
                 c, o, balance, m_exp, m_bal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_warning();
    test_lock();
    test_funds();
    test_limit();
    test_saturate();
    test_hold();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
